// File: rtl/or_gate_pkg.sv
// or_gate_pkg: shared width default and result-update mode for the OR gate cell
package or_gate_pkg;
  localparam int OR_GATE_DEFAULT_WIDTH = 1;
  typedef enum logic {OR_REPLACE, OR_STICKY} or_mode_e;
endpackage

// File: rtl/or_gate_stage.sv
// or_gate_stage: combinational three-input bitwise OR
//   a, b, c : WIDTH-bit operands
//   y       : a | b | c
module or_gate_stage
  import or_gate_pkg::*;
#(
  parameter int WIDTH = OR_GATE_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);
  assign y = a | b | c;
endmodule

// File: rtl/or_gate_unit.sv
// or_gate_unit: registered bitwise OR of two operands with optional sticky accumulation
//   clk, rst_n         : clock, async active-low reset
//   in_valid, in1, in2 : operand beat
//   clear              : synchronous clear of the result
//   out, out_valid     : result and one-cycle valid pulse
//   out_any            : reduction OR of out
module or_gate_unit
  import or_gate_pkg::*;
#(
  parameter int WIDTH  = OR_GATE_DEFAULT_WIDTH,
  parameter int STICKY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             out_any
);
  localparam or_mode_e MODE = (STICKY != 0) ? OR_STICKY : OR_REPLACE;
  logic [WIDTH-1:0] out_q, out_d, fb, sum;
  logic             valid_q, valid_d;
  // clear drops the old value so a colliding beat starts a fresh accumulation
  assign fb = (MODE == OR_STICKY && !clear) ? out_q : '0;
  or_gate_stage #(.WIDTH(WIDTH)) u_stage (.a(in1), .b(in2), .c(fb), .y(sum));
  always_comb begin
    out_d   = in_valid ? sum : (clear ? '0 : out_q);
    valid_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end
  assign out       = out_q;
  assign out_valid = valid_q;
  assign out_any   = |out_q;
endmodule

// File: tb/tb_or_gate_unit.sv
// tb_or_gate_unit: directed and randomized checks of or_gate_unit against a behavioural model
module tb_or_gate_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       v1 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic       o1, ov1, oa1;
  logic       v8 = 0, c8 = 0;
  logic [7:0] a8 = 0, b8 = 0, o8;
  logic       ov8, oa8;
  logic       vs = 0, cs = 0;
  logic [7:0] as = 0, bs = 0, os;
  logic       ovs, oas;
  or_gate_unit #(.WIDTH(1), .STICKY(0)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(v1), .in1(a1), .in2(b1), .clear(c1), .out(o1), .out_valid(ov1), .out_any(oa1));
  or_gate_unit #(.WIDTH(8), .STICKY(0)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(v8), .in1(a8), .in2(b8), .clear(c8), .out(o8), .out_valid(ov8), .out_any(oa8));
  or_gate_unit #(.WIDTH(8), .STICKY(1)) us (.clk(clk), .rst_n(rst_n), .in_valid(vs), .in1(as), .in2(bs), .clear(cs), .out(os), .out_valid(ovs), .out_any(oas));
  int checks = 0, failures = 0;
  bit run = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  // reference model: integer arithmetic on the rules, one entry per instance
  int m_out [3];
  bit m_ov [3];
  function automatic int next_out(int cur, bit v, int a, int b, bit c, bit sticky);
    if (v) return (c || !sticky) ? (a | b) : (cur | a | b);
    return c ? 0 : cur;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= '{0, 0, 0};
      m_ov  <= '{0, 0, 0};
    end else begin
      m_out[0] <= next_out(m_out[0], v1, int'(a1), int'(b1), c1, 0);
      m_out[1] <= next_out(m_out[1], v8, int'(a8), int'(b8), c8, 0);
      m_out[2] <= next_out(m_out[2], vs, int'(as), int'(bs), cs, 1);
      m_ov     <= '{v1, v8, vs};
    end
  end
  always @(negedge clk) begin
    if (run) begin
      chk("model_w1_out", 64'(o1), 64'(m_out[0]));
      chk("model_w1_valid", 64'(ov1), 64'(m_ov[0]));
      chk("model_w1_any", 64'(oa1), 64'(m_out[0] != 0));
      chk("model_w8_out", 64'(o8), 64'(m_out[1]));
      chk("model_w8_valid", 64'(ov8), 64'(m_ov[1]));
      chk("model_w8_any", 64'(oa8), 64'(m_out[1] != 0));
      chk("model_st_out", 64'(os), 64'(m_out[2]));
      chk("model_st_valid", 64'(ovs), 64'(m_ov[2]));
      chk("model_st_any", 64'(oas), 64'(m_out[2] != 0));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [1:0] tt;
    tick();
    tick();
    rst_n = 1'b1;
    run = 1;
    chk("reset_out", 64'(o8), 64'h0);
    chk("reset_valid", 64'(ov8), 64'h0);
    chk("reset_any", 64'(oas), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tt = 2'(i);
      v1 = 1; a1 = tt[1]; b1 = tt[0];
      tick();
      chk($sformatf("truth_out_%0d", i), 64'(o1), (i == 0) ? 64'h0 : 64'h1);
      chk($sformatf("truth_valid_%0d", i), 64'(ov1), 64'h1);
      chk($sformatf("truth_any_%0d", i), 64'(oa1), (i == 0) ? 64'h0 : 64'h1);
    end
    v1 = 0;
    v8 = 1; a8 = 8'hA0; b8 = 8'h0C;
    tick();
    chk("bus_out", 64'(o8), 64'hAC);
    chk("bus_any", 64'(oa8), 64'h1);
    a8 = 8'h00; b8 = 8'h00;
    tick();
    chk("bus_zero_out", 64'(o8), 64'h0);
    chk("bus_zero_any", 64'(oa8), 64'h0);
    a8 = 8'h50; b8 = 8'h05;
    tick();
    chk("hold_load", 64'(o8), 64'h55);
    v8 = 0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      chk("hold_out", 64'(o8), 64'h55);
      chk("hold_valid", 64'(ov8), 64'h0);
    end
    cs = 1;
    tick();
    cs = 0; vs = 1; as = 8'h01; bs = 8'h00;
    tick();
    chk("sticky_1", 64'(os), 64'h01);
    as = 8'h10; bs = 8'h00;
    tick();
    chk("sticky_2", 64'(os), 64'h11);
    as = 8'h00; bs = 8'h80;
    tick();
    chk("sticky_3", 64'(os), 64'h91);
    vs = 0; cs = 1;
    tick();
    chk("sticky_clear_out", 64'(os), 64'h00);
    chk("sticky_clear_valid", 64'(ovs), 64'h0);
    cs = 0; vs = 1; as = 8'hF0; bs = 8'h00;
    tick();
    chk("collide_pre", 64'(os), 64'hF0);
    cs = 1; as = 8'h03;
    tick();
    chk("collide_out", 64'(os), 64'h03);
    cs = 0; vs = 0;
    v8 = 1; a8 = 8'hFF; b8 = 8'h00;
    tick();
    chk("areset_pre", 64'(o8), 64'hFF);
    v8 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("areset_out", 64'(o8), 64'h0);
    chk("areset_valid", 64'(ov8), 64'h0);
    chk("areset_any", 64'(oa8), 64'h0);
    chk("areset_sticky", 64'(os), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("areset_stay_out", 64'(o8), 64'h0);
    chk("areset_stay_any", 64'(oa8), 64'h0);
    v8 = 1; a8 = 8'h3C; b8 = 8'h00;
    tick();
    chk("areset_beat", 64'(o8), 64'h3C);
    for (int i = 0; i < 400; i++) begin
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom); c1 = ($urandom_range(0, 7) == 0);
      v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); c8 = ($urandom_range(0, 7) == 0);
      vs = 1'($urandom); as = 8'($urandom) & 8'($urandom); bs = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cs = ($urandom_range(0, 7) == 0);
      tick();
    end
    v1 = 0; v8 = 0; vs = 0; c1 = 0; c8 = 0; cs = 0;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/or_gate_unit.md
# or_gate_unit

Registered bitwise OR of two operand buses with a valid flag. It is the base logic cell of the gate-library datapath: upstream logic presents two operands with `in_valid`, and the block returns `in1 | in2` one clock later. An optional sticky mode accumulates results until cleared. A one-bit reduction flag reports whether any result bit is set.

## Interface
- `WIDTH`, default 1: operand and result width in bits, legal range 1..64.
- `STICKY`, default 0: 0 means each valid beat replaces the result; 1 means results OR-accumulate until `clear`.
- `clk`  input  1  rising-edge clock for all state.
- `rst_n`  input  1  reset, asynchronous and active-low; asserts immediately, deasserts synchronously to `clk`.
- `in_valid`  input  1  operands are valid this cycle.
- `in1`  input  WIDTH  first operand.
- `in2`  input  WIDTH  second operand.
- `clear`  input  1  synchronous clear of the result register.
- `out`  output  WIDTH  registered OR result.
- `out_valid`  output  1  `out` was updated by the previous cycle's valid beat.
- `out_any`  output  1  reduction OR of `out`.

## Operation
- Non-sticky, `in_valid`=1: `out` <= `in1 | in2`, computed bitwise.
- Sticky, `in_valid`=1: `out` <= `out | in1 | in2`.
- `in_valid`=0: `out` holds its value in both modes.
- `clear`=1, `in_valid`=0: `out` <= 0.
- `clear`=1 and `in_valid`=1 in the same cycle: `clear` takes priority over the old contents, so `out` <= `in1 | in2` with no accumulation of the previous value. This holds in both modes.
- `out_valid` <= `in_valid` on every cycle. It is a single-cycle pulse per beat, and `clear` alone does not raise it.
- `out_any` = `|out`. It is a combinational decode of the register and adds no extra latency.
- Inputs that are X or Z while `in_valid`=0 have no effect on `out`.
- Widths are unchanged through the block: no carry and no truncation.

## Timing
- Reset values: `out`=0, `out_valid`=0, `out_any`=0.
- Reset mid-operation: outputs clear immediately, with no clock edge needed. Any accumulated sticky value is lost.
- Latency: 1 cycle from the `in_valid` edge to `out`/`out_valid`.
- Throughput: one beat per cycle with no back-pressure. Back-to-back beats each produce their own result on consecutive cycles.
- `out_any` settles in the same cycle as `out`.
- No combinational path exists from any input to any output.

## Structure
- Shared package `or_gate_pkg` holds:
  - the `OR_GATE_DEFAULT_WIDTH` constant (1);
  - a `WIDTH`-agnostic mode enum `or_mode_e` = {OR_REPLACE, OR_STICKY}, which the top-level maps onto `STICKY`.
- One natural sub-module, `or_gate_stage`. It is a purely combinational `WIDTH`-bit OR of three vectors (`a | b | c`). The top-level feeds it `in1`, `in2`, and either `out` or 0, depending on the mode and on `clear`.
- The top-level holds the result register, the valid register, and the reduction decode.

## Test plan
- Truth table, `WIDTH`=1, `STICKY`=0, one beat per cycle. Drive (`in1`,`in2`) = (0,0), (0,1), (1,0), (1,1). Required: `out` = 0, 1, 1, 1, each one cycle after its beat, `out_valid` high each cycle, and `out_any` tracking `out`.
- Bus OR, `WIDTH`=8. Drive `in1`=0xA0, `in2`=0x0C. Required: `out`=0xAC and `out_any`=1. Then drive 0x00 with 0x00. Required: `out`=0x00 and `out_any`=0.
- Hold. After a beat producing 0x55, keep `in_valid`=0 for 3 cycles while toggling the operands. Required: `out` stays 0x55 and `out_valid`=0.
- Sticky accumulate, `WIDTH`=8, `STICKY`=1. Send beats 0x01|0x00, then 0x10|0x00, then 0x00|0x80. Required: `out` = 0x01, 0x11, 0x91. Then assert `clear` alone. Required: `out`=0x00 and `out_valid`=0.
- Clear plus valid collision, sticky mode. Start with `out`=0xF0, then assert `clear` with a beat of 0x03|0x00. Required: `out`=0x03.
- Asynchronous reset. Assert `rst_n`=0 between clock edges while `out`=0xFF. Required: `out`, `out_valid` and `out_any` read 0 before the next edge and stay 0 until a beat follows deassertion.
